ast_window_shift: RTL and testbench

- Avalon-ST sink that turns a byte packet stream into sliding byte windows, one window per packet byte.
- Window k of a packet is bytes k..k+WINDOW_SIZE-1 of that packet, truncated at end of packet. Windows never span two packets.
- Up to AST_SINK_SYMBOLS windows leave per output beat, one per output lane.
- Sits between the packet ingress and the hash/bloom-filter lookup stage.

---
 rtl/ast_window_shift_pkg.sv | 12 +
 rtl/ast_window_shift_buf.sv | 83 ++++++++
 rtl/ast_window_shift.sv | 136 +++++++++++++
 tb/tb_ast_window_shift.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_window_shift_pkg.sv
// Shared types and helpers for the sliding-window byte extractor.
package ast_window_shift_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    function automatic int calc_window_size_w(input int window_size);
        return (window_size == 1) ? 1 : $clog2(window_size);
    endfunction

endpackage

// File: rtl/ast_window_shift_buf.sv
// Packet-ordered byte buffer: appends one input word, drops shift_n_i bytes from the head per cycle.
// Ready is combinational from count/eop state; stays low once an eop is held until the packet drains.
module ast_window_shift_buf
    import ast_window_shift_pkg::*;
#(
    parameter int SYMBOLS = 8,
    parameter int ORDER   = 0,
    parameter int CAP     = 35,
    parameter int VIEW    = 27,
    parameter int EMPTY_W = 3,
    parameter int CNT_W   = 6
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [BYTE_W*SYMBOLS-1:0] data_i,
    input  logic [EMPTY_W-1:0]        empty_i,
    input  logic                      eop_i,
    input  logic [CNT_W-1:0]          shift_n_i,
    output byte_t [VIEW-1:0]          bytes_o,
    output logic [CNT_W-1:0]          count_o,
    output logic                      eop_o
);

    byte_t [CAP-1:0]     bytes_q, bytes_d;
    logic  [CNT_W-1:0]   count_q, count_d;
    logic                eop_q, eop_d;
    byte_t [SYMBOLS-1:0] sym;
    logic  [CNT_W-1:0]   in_cnt;
    logic                accept;

    assign ready_o = en_i && !srst_i && !eop_q &&
                     ((CNT_W'(CAP) - count_q) >= CNT_W'(SYMBOLS));
    assign accept  = valid_i && ready_o;
    assign in_cnt  = eop_i ? (CNT_W'(SYMBOLS) - CNT_W'(empty_i)) : CNT_W'(SYMBOLS);

    always_comb begin
        for (int j = 0; j < SYMBOLS; j++) begin
            sym[j] = (ORDER == 0) ? data_i[BYTE_W*j +: BYTE_W]
                                  : data_i[BYTE_W*(SYMBOLS-1-j) +: BYTE_W];
        end
    end

    // New bytes land right behind the bytes that survive this cycle's shift.
    always_comb begin
        int base;
        base = int'(count_q) - int'(shift_n_i);
        for (int k = 0; k < CAP; k++) begin
            bytes_d[k] = (k + int'(shift_n_i) < CAP) ? bytes_q[k + int'(shift_n_i)] : '0;
            for (int j = 0; j < SYMBOLS; j++) begin
                if (accept && (j < int'(in_cnt)) && (k == base + j)) begin
                    bytes_d[k] = sym[j];
                end
            end
        end
        count_d = count_q - shift_n_i + (accept ? in_cnt : '0);
        eop_d   = eop_q;
        if (eop_q && (shift_n_i != '0) && (shift_n_i == count_q)) begin
            eop_d = 1'b0;
        end else if (accept && eop_i) begin
            eop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bytes_q <= '0;
            count_q <= '0;
            eop_q   <= 1'b0;
        end else begin
            bytes_q <= bytes_d;
            count_q <= count_d;
            eop_q   <= eop_d;
        end
    end

    assign bytes_o = bytes_q[VIEW-1:0];
    assign count_o = count_q;
    assign eop_o   = eop_q;

endmodule

// File: rtl/ast_window_shift.sv
// Avalon-ST byte stream to sliding windows, one per byte; registered beat, holds while windows_ready_i=0.
// Define AST_WINDOW_SHIFT_ASSERT_EN to compile protocol/stability checks for simulation.
module ast_window_shift
    import ast_window_shift_pkg::*;
#(
    parameter int AST_SINK_SYMBOLS = 8,
    parameter int AST_SINK_ORDER   = 0,
    parameter int WINDOW_SIZE      = 20,
    parameter int WINDOW_SIZE_W    = calc_window_size_w(WINDOW_SIZE),
    parameter int EMPTY_W          = (AST_SINK_SYMBOLS > 1) ? $clog2(AST_SINK_SYMBOLS) : 1
) (
    input  logic                                              clk_i,
    input  logic                                              srst_i,
    input  logic                                              en_i,
    input  logic                                              ast_sink_valid_i,
    output logic                                              ast_sink_ready_o,
    input  logic [BYTE_W*AST_SINK_SYMBOLS-1:0]                ast_sink_data_i,
    input  logic [EMPTY_W-1:0]                                ast_sink_empty_i,
    input  logic                                              ast_sink_startofpacket_i,
    input  logic                                              ast_sink_endofpacket_i,
    output byte_t [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE-1:0]     windows_data_o,
    output logic  [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE_W:0]     windows_valid_bytes_o,
    input  logic                                              windows_ready_i
);

    localparam int S     = AST_SINK_SYMBOLS;
    localparam int W     = WINDOW_SIZE;
    localparam int CAP   = W - 1 + 2 * S;
    localparam int VIEW  = S + W - 1;
    localparam int CNT_W = $clog2(CAP + 1);
    localparam int VB_W  = WINDOW_SIZE_W + 1;

    byte_t [VIEW-1:0]        buf_bytes;
    logic  [CNT_W-1:0]       buf_count, shift_n;
    logic                    buf_eop;
    byte_t [S-1:0][W-1:0]    data_q, data_d;
    logic  [S-1:0][VB_W-1:0] vb_q, vb_d;
    logic                    beat_vld, load, consume;
    int                      n_win;

    ast_window_shift_buf #(
        .SYMBOLS (S),
        .ORDER   (AST_SINK_ORDER),
        .CAP     (CAP),
        .VIEW    (VIEW),
        .EMPTY_W (EMPTY_W),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .en_i      (en_i),
        .valid_i   (ast_sink_valid_i),
        .ready_o   (ast_sink_ready_o),
        .data_i    (ast_sink_data_i),
        .empty_i   (ast_sink_empty_i),
        .eop_i     (ast_sink_endofpacket_i),
        .shift_n_i (shift_n),
        .bytes_o   (buf_bytes),
        .count_o   (buf_count),
        .eop_o     (buf_eop)
    );

    // A full beat needs enough lookahead for every lane to see a complete window.
    always_comb begin
        int cnt;
        int len;
        cnt    = int'(buf_count);
        n_win  = 0;
        data_d = '0;
        vb_d   = '0;
        if (cnt >= VIEW) begin
            n_win = S;
        end else if (buf_eop && cnt > 0) begin
            n_win = (cnt < S) ? cnt : S;
        end
        for (int i = 0; i < S; i++) begin
            len = 0;
            if (i < n_win) begin
                len = (cnt - i < W) ? (cnt - i) : W;
            end
            vb_d[i] = VB_W'(len);
            for (int j = 0; j < W; j++) begin
                if (j < len) begin
                    data_d[i][j] = buf_bytes[i + j];
                end
            end
        end
    end

    assign beat_vld = |vb_q;
    assign load     = en_i && (n_win != 0) && (!beat_vld || windows_ready_i);
    assign consume  = en_i && beat_vld && windows_ready_i;
    assign shift_n  = load ? CNT_W'(n_win) : '0;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q <= '0;
            vb_q   <= '0;
        end else if (load) begin
            data_q <= data_d;
            vb_q   <= vb_d;
        end else if (consume) begin
            data_q <= '0;
            vb_q   <= '0;
        end
    end

    assign windows_data_o        = data_q;
    assign windows_valid_bytes_o = vb_q;

`ifdef AST_WINDOW_SHIFT_ASSERT_EN
    logic pkt_open_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pkt_open_q <= 1'b0;
        end else if (ast_sink_valid_i && ast_sink_ready_o) begin
            if (ast_sink_startofpacket_i && pkt_open_q)
                $error("ast_window_shift: sop while packet open");
            if (!ast_sink_startofpacket_i && !pkt_open_q)
                $error("ast_window_shift: data without sop");
            if (!ast_sink_endofpacket_i && (ast_sink_empty_i != '0))
                $error("ast_window_shift: nonzero empty on non-eop word");
            pkt_open_q <= !ast_sink_endofpacket_i;
        end
    end

    assert property (@(posedge clk_i) (!srst_i && beat_vld && !windows_ready_i)
                     |=> ($stable(data_q) && $stable(vb_q)))
        else $error("ast_window_shift: output changed while stalled");
`else
    logic sop_unused;
    assign sop_unused = ast_sink_startofpacket_i;
`endif

endmodule

// File: tb/tb_ast_window_shift.sv
// Directed bench for ast_window_shift (8 lanes, 20-byte windows) with a window scoreboard.
module tb_ast_window_shift;

    localparam int S    = 8;
    localparam int WS   = 20;
    localparam int WS_W = 5;
    localparam int EW   = 3;

    typedef logic [WS-1:0][7:0] win_t;

    logic                       clk_i = 1'b0;
    logic                       srst_i;
    logic                       en_i;
    logic                       ast_sink_valid_i;
    logic                       ast_sink_ready_o;
    logic [8*S-1:0]             ast_sink_data_i;
    logic [EW-1:0]              ast_sink_empty_i;
    logic                       ast_sink_startofpacket_i;
    logic                       ast_sink_endofpacket_i;
    logic [S-1:0][WS-1:0][7:0]  windows_data_o;
    logic [S-1:0][WS_W:0]       windows_valid_bytes_o;
    logic                       windows_ready_i;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_mode = 1'b0;
    bit   gap_mode = 1'b0;

    int   got_len[$];
    win_t got_dat[$];
    int   exp_len[$];
    win_t exp_dat[$];

    logic [S-1:0][WS-1:0][7:0] snap_dat;
    logic [S-1:0][WS_W:0]      snap_vb;
    logic [S-1:0][WS_W:0]      exp_vb;

    int sizes[18] = '{1, 2, 3, 7, 8, 9, 15, 19, 20, 21, 26, 27, 28, 29, 35, 36, 47, 64};

    ast_window_shift #(
        .AST_SINK_SYMBOLS (S),
        .AST_SINK_ORDER   (0),
        .WINDOW_SIZE      (WS)
    ) dut (
        .clk_i                    (clk_i),
        .srst_i                   (srst_i),
        .en_i                     (en_i),
        .ast_sink_valid_i         (ast_sink_valid_i),
        .ast_sink_ready_o         (ast_sink_ready_o),
        .ast_sink_data_i          (ast_sink_data_i),
        .ast_sink_empty_i         (ast_sink_empty_i),
        .ast_sink_startofpacket_i (ast_sink_startofpacket_i),
        .ast_sink_endofpacket_i   (ast_sink_endofpacket_i),
        .windows_data_o           (windows_data_o),
        .windows_valid_bytes_o    (windows_valid_bytes_o),
        .windows_ready_i          (windows_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Record every window of a beat that the next rising edge will consume.
    always @(negedge clk_i) begin
        if (!srst_i && en_i && windows_ready_i) begin
            for (int i = 0; i < S; i++) begin
                if (windows_valid_bytes_o[i] != '0) begin
                    got_len.push_back(int'(windows_valid_bytes_o[i]));
                    got_dat.push_back(windows_data_o[i]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_ready();
        if (bp_mode) begin
            cyc++;
            windows_ready_i = (cyc % 4 != 3) && (cyc % 11 != 5);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        step_ready();
    endtask

    task automatic push_exp(input int len, input int base);
        for (int k = 0; k < len; k++) begin
            win_t d;
            int   l;
            d = '0;
            l = (len - k < WS) ? (len - k) : WS;
            for (int j = 0; j < l; j++) d[j] = 8'(base + k + j);
            exp_len.push_back(l);
            exp_dat.push_back(d);
        end
    endtask

    task automatic send_word(input int base, input int nv, input bit s, input bit e);
        logic acc;
        for (int j = 0; j < S; j++) ast_sink_data_i[8*j +: 8] = (j < nv) ? 8'(base + j) : 8'h00;
        ast_sink_valid_i         = 1'b1;
        ast_sink_startofpacket_i = s;
        ast_sink_endofpacket_i   = e;
        ast_sink_empty_i         = e ? EW'(S - nv) : '0;
        acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk_i);
            acc = ast_sink_ready_o;
            tick();
        end
        chk("send_accept", acc, 1'b1);
        ast_sink_valid_i         = 1'b0;
        ast_sink_startofpacket_i = 1'b0;
        ast_sink_endofpacket_i   = 1'b0;
        ast_sink_empty_i         = '0;
    endtask

    task automatic send_pkt(input int len, input int base);
        int nw;
        push_exp(len, base);
        nw = (len + S - 1) / S;
        for (int w = 0; w < nw; w++) begin
            if (gap_mode) repeat (w % 3) tick();
            send_word(base + S * w, (len - S * w < S) ? (len - S * w) : S, w == 0, w == nw - 1);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (got_len.size() < exp_len.size() && t < 3000) begin
            tick();
            t++;
        end
        repeat (6) tick();
        chk("win_count", got_len.size(), exp_len.size());
        while (exp_len.size() > 0 && got_len.size() > 0) begin
            chk("win_len", got_len.pop_front(), exp_len.pop_front());
            chk("win_dat", got_dat.pop_front(), exp_dat.pop_front());
        end
        got_len.delete();
        got_dat.delete();
        exp_len.delete();
        exp_dat.delete();
    endtask

    initial begin
        srst_i                   = 1'b1;
        en_i                     = 1'b1;
        ast_sink_valid_i         = 1'b0;
        ast_sink_data_i          = '0;
        ast_sink_empty_i         = '0;
        ast_sink_startofpacket_i = 1'b0;
        ast_sink_endofpacket_i   = 1'b0;
        windows_ready_i          = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_vb", windows_valid_bytes_o, '0);
        chk("rst_dat0", windows_data_o[0], '0);
        chk("rst_ready", ast_sink_ready_o, 1'b0);
        srst_i = 1'b0;
        tick();
        chk("idle_ready", ast_sink_ready_o, 1'b1);

        // 1-byte packet: nothing on the acceptance edge, one lane the cycle after
        send_pkt(1, 1);
        chk("lat_vb", windows_valid_bytes_o, '0);
        tick();
        exp_vb = '0;
        exp_vb[0] = 6'd1;
        chk("one_vb", windows_valid_bytes_o, exp_vb);
        chk("one_dat", windows_data_o[0][0], 8'd1);
        drain();

        // Packet exactly one window long
        send_pkt(20, 1);
        drain();

        // 28-byte packet: first beat is eight full windows starting at 1..8
        send_pkt(28, 1);
        tick();
        for (int i = 0; i < S; i++) exp_vb[i] = 6'd20;
        chk("b28_vb", windows_valid_bytes_o, exp_vb);
        for (int i = 0; i < S; i++) chk("b28_start", windows_data_o[i][0], 8'(i + 1));
        drain();

        // Downstream stall for 10 cycles
        windows_ready_i = 1'b0;
        send_pkt(28, 40);
        tick();
        chk("stall_first", windows_data_o[0][0], 8'd40);
        snap_dat = windows_data_o;
        snap_vb  = windows_valid_bytes_o;
        repeat (10) begin
            tick();
            chk("stall_vb", windows_valid_bytes_o, snap_vb);
            for (int i = 0; i < S; i++) chk("stall_dat", windows_data_o[i], snap_dat[i]);
        end
        windows_ready_i = 1'b1;
        drain();

        // en_i low for 5 cycles with a beat pending and a word offered
        windows_ready_i = 1'b0;
        push_exp(36, 100);
        send_word(100, 8, 1'b1, 1'b0);
        send_word(108, 8, 1'b0, 1'b0);
        send_word(116, 8, 1'b0, 1'b0);
        send_word(124, 8, 1'b0, 1'b0);
        tick();
        snap_dat = windows_data_o;
        snap_vb  = windows_valid_bytes_o;
        chk("en_beat", windows_data_o[7][0], 8'd107);
        en_i = 1'b0;
        windows_ready_i = 1'b1;
        for (int j = 0; j < S; j++) ast_sink_data_i[8*j +: 8] = (j < 4) ? 8'(132 + j) : 8'h00;
        ast_sink_empty_i       = EW'(4);
        ast_sink_endofpacket_i = 1'b1;
        ast_sink_valid_i       = 1'b1;
        repeat (5) begin
            tick();
            chk("en_ready", ast_sink_ready_o, 1'b0);
            chk("en_vb", windows_valid_bytes_o, snap_vb);
            for (int i = 0; i < S; i++) chk("en_dat", windows_data_o[i], snap_dat[i]);
        end
        en_i = 1'b1;
        send_word(132, 4, 1'b0, 1'b1);
        drain();

        // Reset mid-packet drops buffered bytes and the pending beat
        send_word(7, 8, 1'b1, 1'b0);
        send_word(15, 8, 1'b0, 1'b0);
        send_word(23, 8, 1'b0, 1'b0);
        send_word(31, 8, 1'b0, 1'b0);
        tick();
        srst_i = 1'b1;
        tick();
        chk("srst_vb", windows_valid_bytes_o, '0);
        chk("srst_ready", ast_sink_ready_o, 1'b0);
        srst_i = 1'b0;
        got_len.delete();
        got_dat.delete();
        exp_len.delete();
        exp_dat.delete();
        tick();
        chk("post_srst_ready", ast_sink_ready_o, 1'b1);
        send_pkt(9, 200);
        drain();

        // Back-to-back packets with input gaps and toggling downstream ready
        bp_mode  = 1'b1;
        gap_mode = 1'b1;
        foreach (sizes[p]) send_pkt(sizes[p], sizes[p] * 7);
        drain();
        bp_mode  = 1'b0;
        gap_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
